// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared constants and helpers for the PS/2 keyboard front end.
// Scan-code set 2 prefixes and the receiver state type live here.
package ps2_key_event_decoder_pkg;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PREFIX_PAUSE = 8'hE1;
   localparam logic [7:0] PS2_FAKE_SHIFT   = 8'h12;
   localparam logic [2:0] PS2_PAUSE_SKIP   = 3'd7;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_RECV = 1'b1
   } rx_state_e;

   // Keyboard replies (ACK, BAT, echo, resend, errors) carry no key information.
   function automatic logic is_ignored_byte(input logic [7:0] b);
      return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
             (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_key_event_decoder_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, ps2_clk glitch filter,
// 11-bit framing with odd parity check, and an idle timeout that drops partial frames.
module ps2_frame_rx
   import ps2_key_event_decoder_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] byte_data_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          fall;
   logic          bit_in;

   rx_state_e     state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    byte_q;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          stop_ok;

   // ps2_clk level only flips after FILTER_LEN consecutive samples disagree with it
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = '0;
      fall       = 1'b0;
      if (clk_sync_q[1] != filt_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = clk_sync_q[1];
            fall   = filt_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   assign bit_in = data_sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_q      <= 1'b1;
         filt_cnt_q  <= '0;
         state_q     <= RX_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_q       <= '0;
         byte_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
         data_sync_q <= {data_sync_q[0], ps2_data_i};
         filt_q      <= filt_d;
         filt_cnt_q  <= filt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tmo_q       <= tmo_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         if (valid_d) byte_q <= shift_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tmo_d     = tmo_q;
      case (state_q)
         RX_IDLE: begin
            tmo_d = '0;
            if (fall && !bit_in) begin
               state_d   = RX_RECV;
               bit_cnt_d = '0;
            end
         end
         RX_RECV: begin
            if (fall) begin
               tmo_d     = '0;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q < 4'd8)       shift_d = {bit_in, shift_q[7:1]};
               else if (bit_cnt_q == 4'd8) par_d   = bit_in;
               else                        state_d = RX_IDLE;
            end else if (tmo_q == TW'(TIMEOUT_CYC)) begin
               state_d = RX_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // odd parity over data+parity, stop bit must be high
   assign stop_ok = bit_in && (^{shift_q, par_q});

   always_comb begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (fall) begin
         if (state_q == RX_IDLE) begin
            err_d = bit_in;
         end else if (bit_cnt_q == 4'd9) begin
            valid_d = stop_ok;
            err_d   = !stop_ok;
         end
      end
   end

   assign byte_data_o  = byte_q;
   assign byte_valid_o = valid_q;
   assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code set 2 key-event decoder: turns received bytes into make/break
// events and maintains the 512-entry held-key map with a one-cycle update strobe.
module ps2_key_event_decoder
   import ps2_key_event_decoder_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         PS2_CLK,
   input  logic         PS2_DATA,
   output logic [511:0] key_down,
   output logic [8:0]   last_change,
   output logic         been_ready,
   output logic         frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [2:0] D_IDLE    = 3'd0;
   localparam logic [2:0] D_EXT     = 3'd1;
   localparam logic [2:0] D_BRK     = 3'd2;
   localparam logic [2:0] D_EXT_BRK = 3'd3;
   localparam logic [2:0] D_PAUSE   = 3'd4;

   logic [7:0]    byte_data;
   logic          byte_valid;

   logic [2:0]    dec_q, dec_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] ptmo_q, ptmo_d;
   logic [511:0]  key_down_q;
   logic [8:0]    last_change_q;
   logic          ready_q;

   logic          ev_valid;
   logic          ev_make;
   logic [8:0]    ev_code;

   ps2_frame_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .ps2_clk_i    (PS2_CLK),
      .ps2_data_i   (PS2_DATA),
      .byte_data_o  (byte_data),
      .byte_valid_o (byte_valid),
      .frame_err_o  (frame_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_q  <= D_IDLE;
         skip_q <= '0;
         ptmo_q <= '0;
      end else begin
         dec_q  <= dec_d;
         skip_q <= skip_d;
         ptmo_q <= ptmo_d;
      end
   end

   always_comb begin
      dec_d  = dec_q;
      skip_d = skip_q;
      ptmo_d = '0;
      if (byte_valid) begin
         case (dec_q)
            D_IDLE: begin
               if (byte_data == PS2_PREFIX_EXT) begin
                  dec_d = D_EXT;
               end else if (byte_data == PS2_PREFIX_BRK) begin
                  dec_d = D_BRK;
               end else if (byte_data == PS2_PREFIX_PAUSE) begin
                  dec_d  = D_PAUSE;
                  skip_d = PS2_PAUSE_SKIP;
               end
            end
            D_EXT:   dec_d = (byte_data == PS2_PREFIX_BRK) ? D_EXT_BRK : D_IDLE;
            D_PAUSE: begin
               skip_d = skip_q - 1'b1;
               if (skip_q <= 3'd1) dec_d = D_IDLE;
            end
            default: dec_d = D_IDLE;
         endcase
      end else if (dec_q != D_IDLE) begin
         // a prefix that is never completed must not capture a later unrelated byte
         if (ptmo_q == TW'(TIMEOUT_CYC)) dec_d  = D_IDLE;
         else                            ptmo_d = ptmo_q + 1'b1;
      end
   end

   always_comb begin
      ev_valid = 1'b0;
      ev_make  = 1'b1;
      ev_code  = {1'b0, byte_data};
      if (byte_valid) begin
         case (dec_q)
            D_IDLE: begin
               ev_valid = (byte_data != PS2_PREFIX_EXT) && (byte_data != PS2_PREFIX_BRK) &&
                          (byte_data != PS2_PREFIX_PAUSE) && !is_ignored_byte(byte_data);
            end
            D_EXT: begin
               ev_valid = (byte_data != PS2_PREFIX_BRK) && (byte_data != PS2_FAKE_SHIFT);
               ev_code  = {1'b1, byte_data};
            end
            D_BRK: begin
               ev_valid = 1'b1;
               ev_make  = 1'b0;
            end
            D_EXT_BRK: begin
               ev_valid = (byte_data != PS2_FAKE_SHIFT);
               ev_make  = 1'b0;
               ev_code  = {1'b1, byte_data};
            end
            default: ev_valid = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_down_q    <= '0;
         last_change_q <= '0;
         ready_q       <= 1'b0;
      end else begin
         ready_q <= ev_valid;
         if (ev_valid) begin
            key_down_q[ev_code] <= ev_make;
            last_change_q       <= ev_code;
         end
      end
   end

   assign key_down    = key_down_q;
   assign last_change = last_change_q;
   assign been_ready  = ready_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: drives PS/2 frames on the pins and
// checks every been_ready strobe against the queued expected key event.
module tb_ps2_key_event_decoder;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 2000;
   localparam int HALF        = 200;

   typedef struct packed {
      logic [8:0] code;
      logic       down;
   } sb_ent_t;

   logic         clk;
   logic         rst;
   logic         PS2_CLK;
   logic         PS2_DATA;
   logic [511:0] key_down;
   logic [8:0]   last_change;
   logic         been_ready;
   logic         frame_err;

   sb_ent_t      sb[$];
   sb_ent_t      e_m;
   int           n_cmp;
   int           n_err;
   int           fe_cnt;
   int           fe_before;
   logic         prev_ready;
   logic         prev_fe;
   logic         seen_075;
   logic [511:0] kd_save;

   ps2_key_event_decoder #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .PS2_CLK     (PS2_CLK),
      .PS2_DATA    (PS2_DATA),
      .key_down    (key_down),
      .last_change (last_change),
      .been_ready  (been_ready),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [8:0] code, input logic down);
      sb_ent_t e;
      e.code = code;
      e.down = down;
      sb.push_back(e);
   endtask

   task automatic send_bit(input logic b);
      PS2_DATA = b;
      #HALF;
      PS2_CLK = 1'b0;
      #HALF;
      PS2_CLK = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~^b ^ bad_par);
      send_bit(1'b1);
      #(8 * HALF);
   endtask

   // Strobe-side scoreboard checker plus pulse-width and sticky observations
   always @(negedge clk) begin
      if (!rst) begin
         if (been_ready) begin
            chk("ready_width", prev_ready, 1'b0);
            if (sb.size() == 0) begin
               chk("spurious_ready", been_ready, 1'b0);
            end else begin
               e_m = sb.pop_front();
               chk("last_change", last_change, e_m.code);
               chk("key_state", key_down[e_m.code], e_m.down);
            end
         end
         if (frame_err) begin
            fe_cnt++;
            chk("err_width", prev_fe, 1'b0);
         end
         if (key_down[9'h075]) seen_075 = 1'b1;
         prev_ready = been_ready;
         prev_fe    = frame_err;
      end else begin
         prev_ready = 1'b0;
         prev_fe    = 1'b0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d events pending", sb.size());
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      fe_cnt   = 0;
      seen_075 = 1'b0;
      rst      = 1'b1;
      PS2_CLK  = 1'b1;
      PS2_DATA = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      chk("rst_key_down", key_down, '0);
      chk("rst_last_change", last_change, 9'h000);
      chk("rst_been_ready", been_ready, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);

      // W press and release
      push(9'h01D, 1'b1);
      send_frame(8'h1D, 1'b0);
      chk("w_down", key_down[9'h01D], 1'b1);
      push(9'h01D, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1D, 1'b0);
      chk("w_up", key_down[9'h01D], 1'b0);

      // extended key press and release
      push(9'h175, 1'b1);
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk("ext_down", key_down[9'h175], 1'b1);
      chk("ext_lc", last_change, 9'h175);
      push(9'h175, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk("ext_up", key_down[9'h175], 1'b0);
      chk("no_075", seen_075, 1'b0);

      // extended fake shift is swallowed
      send_frame(8'hE0, 1'b0);
      send_frame(8'h12, 1'b0);
      chk("fake_shift", key_down[9'h112] | key_down[9'h012], 1'b0);

      // parity error dropped, then good frame accepted
      kd_save   = key_down;
      fe_before = fe_cnt;
      send_frame(8'h1C, 1'b1);
      chk("parity_err_cnt", fe_cnt - fe_before, 1);
      chk("parity_keys", key_down, kd_save);
      push(9'h01C, 1'b1);
      send_frame(8'h1C, 1'b0);
      chk("good_1c", key_down[9'h01C], 1'b1);

      // start error
      fe_before = fe_cnt;
      send_bit(1'b1);
      #(8 * HALF);
      chk("start_err_cnt", fe_cnt - fe_before, 1);

      // partial frame abandoned by timeout
      fe_before = fe_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      repeat (TIMEOUT_CYC + 200) @(posedge clk);
      push(9'h023, 1'b1);
      send_frame(8'h23, 1'b0);
      chk("timeout_no_err", fe_cnt - fe_before, 0);
      chk("timeout_23", key_down[9'h023], 1'b1);

      // stale prefix discarded
      send_frame(8'hE0, 1'b0);
      repeat (TIMEOUT_CYC + 300) @(posedge clk);
      push(9'h06B, 1'b1);
      send_frame(8'h6B, 1'b0);
      chk("prefix_tmo_ext", key_down[9'h16B], 1'b0);

      // typematic repeat and break of a key already up both strobe
      push(9'h01C, 1'b1);
      send_frame(8'h1C, 1'b0);
      push(9'h02B, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h2B, 1'b0);

      // keyboard ACK ignored
      send_frame(8'hFA, 1'b0);
      chk("ack_hold", last_change, 9'h02B);

      // reset mid-prefix
      chk("pre_rst_keys", key_down[9'h01C], 1'b1);
      send_frame(8'hE0, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #4;
      chk("midrst_keys", key_down, '0);
      chk("midrst_lc", last_change, 9'h000);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      push(9'h075, 1'b1);
      send_frame(8'h75, 1'b0);
      chk("post_rst_075", key_down[9'h075], 1'b1);
      chk("post_rst_175", key_down[9'h175], 1'b0);

      // pause sequence yields nothing
      send_frame(8'hE1, 1'b0);
      send_frame(8'h14, 1'b0);
      send_frame(8'h77, 1'b0);
      send_frame(8'hE1, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h14, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h77, 1'b0);
      chk("pause_lc", last_change, 9'h075);
      push(9'h01B, 1'b1);
      send_frame(8'h1B, 1'b0);
      chk("after_pause_1b", key_down[9'h01B], 1'b1);
      chk("pause_14", key_down[9'h014], 1'b0);
      chk("pause_77", key_down[9'h077], 1'b0);

      repeat (50) @(posedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
